histogram_equalizer: RTL

- Sits directly downstream of the total-histogram stage.
- After each frame's histogram completes, it reads the cumulative histogram through that stage's read port. It then builds a 256-entry equalisation LUT with a sequential divider.
- It remaps the live gray pixel stream through the LUT.
- The LUT is double-buffered: a new LUT is built in the shadow bank and becomes active only at the next frame start, so frames are never torn.

---
 rtl/histogram_equalizer_if.sv | 23 ++
 rtl/histogram_equalizer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/histogram_equalizer_if.sv
// histogram_equalizer_if: pixel stream, cumulative-histogram read port and build status
interface histogram_equalizer_if #(
  parameter int CDF_W = 20
);
  logic             iFvalid;
  logic [7:0]       iGray;
  logic             iGrayValid;
  logic             iHistDone;
  logic [CDF_W-1:0] iCumHisto;
  logic [7:0]       oReadGray;
  logic [7:0]       oEqGray;
  logic             oEqValid;
  logic             oBusy;
  logic             oLutReady;
  modport master (
    output iFvalid, iGray, iGrayValid, iHistDone, iCumHisto,
    input  oReadGray, oEqGray, oEqValid, oBusy, oLutReady
  );
  modport slave (
    input  iFvalid, iGray, iGrayValid, iHistDone, iCumHisto,
    output oReadGray, oEqGray, oEqValid, oBusy, oLutReady
  );
endinterface

// File: rtl/histogram_equalizer.sv
// histogram_equalizer: builds a double-buffered equalisation LUT from the CDF and remaps gray pixels
module histogram_equalizer #(
  parameter int TOTAL_PIXELS = 384000,
  parameter int CDF_W        = 20
) (
  input logic                  iClk,
  input logic                  iRst_n,
  histogram_equalizer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SCAN_ADDR, SCAN_CAP, BUILD_ADDR, BUILD_CAP, DIV, WRITE, DONE} state_t;
  localparam logic [CDF_W-1:0] TOTAL = CDF_W'(TOTAL_PIXELS);
  state_t           state_q, state_d;
  logic             hist_done_q, fvalid_q, hist_rise, fv_rise, swap;
  logic [7:0]       g_q, g_d, read_gray_q, read_gray_d, quo_q, quo_d, wr_data;
  logic [2:0]       cnt_q, cnt_d;
  logic [CDF_W-1:0] cdf_min_q, cdf_min_d, den_q, den_d, diff;
  logic [27:0]      rem_q, rem_d, den_sh;
  logic             busy, lut_ready, wr_en, ge;
  logic             bank_q, bank_d, lut_valid_q, lut_valid_d, pend_q, pend_d;
  logic [7:0]       gray1_q, eq_gray_q, eq_gray_d, rd_data;
  logic             gv1_q, eq_valid_q;
  logic [7:0]       lut_q [2][256];
  assign hist_rise = bus.iHistDone & ~hist_done_q;
  assign fv_rise   = bus.iFvalid & ~fvalid_q;
  assign swap      = fv_rise & pend_q;
  // build FSM state register; reset aborts any build in progress
  always_ff @(posedge iClk) state_q <= !iRst_n ? IDLE : state_d;
  // next-state: scan for first non-empty bin, then 11 cycles per LUT entry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       state_d = hist_rise ? SCAN_ADDR : IDLE;
      SCAN_ADDR:  state_d = SCAN_CAP;
      SCAN_CAP:   state_d = (bus.iCumHisto != '0 || g_q == 8'd255) ? BUILD_ADDR : SCAN_ADDR;
      BUILD_ADDR: state_d = BUILD_CAP;
      BUILD_CAP:  state_d = DIV;
      DIV:        state_d = cnt_q == 3'd0 ? WRITE : DIV;
      WRITE:      state_d = g_q == 8'd255 ? DONE : BUILD_ADDR;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end
  // FSM outputs; a flat image (zero denominator) maps every level to itself
  always_comb begin
    busy      = state_q != IDLE && state_q != DONE;
    lut_ready = state_q == DONE;
    wr_en     = state_q == WRITE && iRst_n;
    wr_data   = den_q == '0 ? g_q : quo_q;
  end
  // scan/build datapath: cdf_min capture, numerator/denominator setup, restoring divide
  always_comb begin
    g_d       = g_q;
    cdf_min_d = cdf_min_q;
    den_d     = den_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    diff      = bus.iCumHisto - cdf_min_q;
    den_sh    = 28'(den_q) << cnt_q;
    ge        = rem_q >= den_sh;
    case (state_q)
      IDLE: g_d = 8'd0;
      SCAN_CAP: begin
        cdf_min_d = bus.iCumHisto;
        g_d       = (bus.iCumHisto != '0 || g_q == 8'd255) ? 8'd0 : g_q + 8'd1;
      end
      BUILD_CAP: begin
        rem_d = bus.iCumHisto < cdf_min_q ? 28'd0 : 28'(diff) * 28'd255;
        den_d = TOTAL - cdf_min_q;
        cnt_d = 3'd7;
        quo_d = 8'd0;
      end
      DIV: begin
        rem_d = ge ? rem_q - den_sh : rem_q;
        quo_d = {quo_q[6:0], ge};
        cnt_d = cnt_q - 3'd1;
      end
      WRITE: g_d = g_q + 8'd1;
      default: ;
    endcase
    read_gray_d = (state_d == SCAN_ADDR || state_d == BUILD_ADDR) ? g_d : read_gray_q;
  end
  // bank swap at frame start only, so a frame never sees a half-written LUT
  always_comb begin
    bank_d      = bank_q ^ swap;
    lut_valid_d = lut_valid_q | swap;
    pend_d      = lut_ready | (pend_q & ~swap);
    rd_data     = lut_q[bank_q][gray1_q];
    eq_gray_d   = !gv1_q ? 8'd0 : lut_valid_q ? rd_data : gray1_q;
  end
  // datapath, bank control and pixel pipeline registers
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      hist_done_q <= 1'b0;
      fvalid_q    <= 1'b0;
      g_q         <= 8'd0;
      read_gray_q <= 8'd0;
      quo_q       <= 8'd0;
      cnt_q       <= 3'd0;
      cdf_min_q   <= '0;
      den_q       <= '0;
      rem_q       <= 28'd0;
      bank_q      <= 1'b0;
      lut_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      gray1_q     <= 8'd0;
      gv1_q       <= 1'b0;
      eq_gray_q   <= 8'd0;
      eq_valid_q  <= 1'b0;
    end else begin
      hist_done_q <= bus.iHistDone;
      fvalid_q    <= bus.iFvalid;
      g_q         <= g_d;
      read_gray_q <= read_gray_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      cdf_min_q   <= cdf_min_d;
      den_q       <= den_d;
      rem_q       <= rem_d;
      bank_q      <= bank_d;
      lut_valid_q <= lut_valid_d;
      pend_q      <= pend_d;
      gray1_q     <= bus.iGray;
      gv1_q       <= bus.iGrayValid;
      eq_gray_q   <= eq_gray_d;
      eq_valid_q  <= gv1_q;
    end
  end
  // LUT storage; builds only ever write the shadow bank
  always_ff @(posedge iClk) if (wr_en) lut_q[~bank_q][g_q] <= wr_data;
  assign bus.oReadGray = read_gray_q;
  assign bus.oEqGray   = eq_gray_q;
  assign bus.oEqValid  = eq_valid_q;
  assign bus.oBusy     = busy;
  assign bus.oLutReady = lut_ready;
endmodule
